alu_share_ctrl: RTL

- Sequencer/arbiter that time-shares one combinational ALU instance between two requesters: requester 0 is the integer pipeline, requester 1 is the address/branch-compare unit.
- Each requester presents operands and the 4-bit ALU control code {instr[30], instr[14:12]} over a valid/ready handshake.
- The block registers the operands and drives the shared ALU, then captures result and flags into a response register held until the owner accepts it.
- At most one operation is outstanding.

---
 rtl/alu_share_ctrl_pkg.sv | 32 +++
 rtl/alu_share_ctrl_rr_arb2.sv | 19 +
 rtl/alu_share_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU time-sharing controller: control codes,
// FSM encoding, flag positions and the carry/overflow qualification rule.
package alu_share_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    // C/O are only meaningful for add/subtract; aluop=0 always means ADD.
    function automatic logic carry_valid(input logic aluop, input logic [3:0] ctrl);
        return !aluop || (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_winner ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between the integer pipeline (req 0)
// and the address/branch-compare unit (req 1); one op outstanding at a time.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRIO_RESET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_ctrl0,
    input  logic [3:0]       req_ctrl1,
    input  logic             req_aluop0,
    input  logic             req_aluop1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_c,
    input  logic             alu_o,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
        logic             aluop;
    } op_t;

    // last_winner starts as the other requester so PRIO_RESET takes the first tie.
    localparam logic LW_RST = (PRIO_RESET == 0);

    state_t     state, state_nxt;
    op_t        op_reg;
    logic       owner;
    logic       last_winner;
    logic [1:0] gnt;
    logic       sel;
    logic       accept;

    rr_arb2 u_arb (
        .req        (req_valid),
        .last_winner(last_winner),
        .gnt        (gnt)
    );

    assign sel    = gnt[1];
    assign accept = (state == ST_IDLE) && (gnt != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready[owner]) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state)
            ST_IDLE: req_ready = gnt;
            ST_RESP: rsp_valid[owner] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg      <= '0;
            owner       <= 1'b0;
            last_winner <= LW_RST;
            rsp_result  <= '0;
            rsp_flags   <= 4'b0000;
        end else begin
            if (accept) begin
                op_reg      <= sel ? op_t'{req_a1, req_b1, req_ctrl1, req_aluop1}
                                   : op_t'{req_a0, req_b0, req_ctrl0, req_aluop0};
                owner       <= sel;
                last_winner <= sel;
            end
            if (state == ST_EXEC) begin
                rsp_result        <= alu_result;
                rsp_flags[FLAG_Z] <= alu_z;
                rsp_flags[FLAG_N] <= alu_n;
                rsp_flags[FLAG_C] <= alu_c & carry_valid(op_reg.aluop, op_reg.ctrl);
                rsp_flags[FLAG_O] <= alu_o & carry_valid(op_reg.aluop, op_reg.ctrl);
            end
        end
    end

    // The ALU always sees op_reg, so its inputs are defined from reset onward.
    assign alu_a    = op_reg.a;
    assign alu_b    = op_reg.b;
    assign alu_ctrl = op_reg.ctrl;
    assign alu_op   = op_reg.aluop;

endmodule
